// File: rtl/ahb2apb_ctrl.sv
// AHB-to-APB bridge controller: single-transfer AHB slave driving up to four APB slaves.
// Moore FSM; every bus-facing output is registered alongside the state.

module ahb2apb_ctrl (
    input  logic        Hclk,
    input  logic        Hrst,
    input  logic        Hsel,
    input  logic [31:0] Haddr,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [31:0] Hwdata,
    input  logic        Hready_in,
    output logic        Hready_out,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic [31:0] Paddr,
    output logic        Pwrite,
    output logic [31:0] Pwdata,
    output logic [3:0]  Psel,
    output logic        Penable,
    input  logic [31:0] Prdata_m,
    input  logic        Pready
);

    typedef enum logic [2:0] {
        StIdle,
        StWlatch,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    state_e state_q;
    logic   accept;
    logic   decode_err;
    logic   unused_htrans;

    // ERR2 already drives Hready_out=1, so it may take a new transfer just like IDLE.
    assign accept        = ((state_q == StIdle) || (state_q == StErr2)) &&
                           Hsel && Htrans[1] && Hready_in;
    assign decode_err    = Haddr[11:8] > 4'd3;
    assign unused_htrans = Htrans[0];

    function automatic logic [3:0] sel_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_ff @(posedge Hclk) begin
        if (Hrst) begin
            state_q    <= StIdle;
            Hready_out <= 1'b1;
            Hresp      <= 2'b00;
            Hrdata     <= '0;
            Paddr      <= '0;
            Pwrite     <= 1'b0;
            Pwdata     <= '0;
            Psel       <= '0;
            Penable    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StErr2: begin
                    state_q    <= StIdle;
                    Hready_out <= 1'b1;
                    Hresp      <= 2'b00;
                    if (accept) begin
                        Paddr      <= Haddr;
                        Pwrite     <= Hwrite;
                        Hready_out <= 1'b0;
                        if (decode_err) begin
                            state_q <= StErr1;
                            Hresp   <= 2'b01;
                        end else if (Hwrite) begin
                            state_q <= StWlatch;
                        end else begin
                            state_q <= StSetup;
                            Psel    <= sel_onehot(Haddr[9:8]);
                        end
                    end
                end
                StWlatch: begin
                    // Write data is only valid in the AHB data phase, one cycle after address.
                    Pwdata  <= Hwdata;
                    Psel    <= sel_onehot(Paddr[9:8]);
                    state_q <= StSetup;
                end
                StSetup: begin
                    Penable <= 1'b1;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (Pready) begin
                        state_q    <= StIdle;
                        Psel       <= '0;
                        Penable    <= 1'b0;
                        Hready_out <= 1'b1;
                        if (!Pwrite) begin
                            Hrdata <= Prdata_m;
                        end
                    end
                end
                StErr1: begin
                    // Two-cycle ERROR response: Hresp held, Hready_out raised in ERR2.
                    Hready_out <= 1'b1;
                    state_q    <= StErr2;
                end
                default: begin
                    state_q    <= StIdle;
                    Hready_out <= 1'b1;
                    Hresp      <= 2'b00;
                    Psel       <= '0;
                    Penable    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb_ctrl.sv
// Randomised scoreboard bench for ahb2apb_ctrl: the driver queues expected transfer outcomes,
// a negedge monitor pops and compares them as the bridge completes each transfer.

module tb_ahb2apb_ctrl;

    logic        Hclk, Hrst, Hsel, Hwrite, Hready_in;
    logic [31:0] Haddr, Hwdata;
    logic [1:0]  Htrans;
    logic        Hready_out;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata, Paddr, Pwdata;
    logic        Pwrite, Penable;
    logic [3:0]  Psel;
    logic [31:0] Prdata_m;
    logic        Pready;

    ahb2apb_ctrl dut (
        .Hclk       (Hclk),
        .Hrst       (Hrst),
        .Hsel       (Hsel),
        .Haddr      (Haddr),
        .Htrans     (Htrans),
        .Hwrite     (Hwrite),
        .Hwdata     (Hwdata),
        .Hready_in  (Hready_in),
        .Hready_out (Hready_out),
        .Hresp      (Hresp),
        .Hrdata     (Hrdata),
        .Paddr      (Paddr),
        .Pwrite     (Pwrite),
        .Pwdata     (Pwdata),
        .Psel       (Psel),
        .Penable    (Penable),
        .Prdata_m   (Prdata_m),
        .Pready     (Pready)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic [31:0] prev_rdata;
        bit          err;
        int          lat;
        int          waits;
        int          acc;
    } item_t;

    item_t       q[$];
    item_t       mon_it;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          pen_cnt = 0;
    int          setup_cnt = 0;
    int          mon_n;
    logic [3:0]  exp_psel;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_addr = '0;
    int          cur_waits = 0;
    logic [31:0] cur_rdata = '0;
    int          acc_cnt = 0;

    always @(posedge Hclk) cyc++;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // APB slave model: stalls for cur_waits ACCESS cycles, junk on Prdata_m/Pready elsewhere.
    always @(negedge Hclk) begin
        if (Psel != 4'b0 && Penable) begin
            Pready   = (acc_cnt >= cur_waits);
            Prdata_m = cur_rdata;
            acc_cnt++;
        end else begin
            acc_cnt  = 0;
            Pready   = 1'($urandom);
            Prdata_m = $urandom;
        end
    end

    // Monitor / scoreboard.
    always @(negedge Hclk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                pen_cnt   = 0;
                setup_cnt = 0;
                chk(Hready_out && Hresp == 2'b00 && Psel == 4'b0 && !Penable, "idle_outputs",
                    {24'b0, Hready_out, Hresp, Psel, Penable}, 32'h80);
                chk(Paddr == last_addr, "idle_paddr", Paddr, last_addr);
                chk(Hrdata == last_rdata, "idle_hrdata", Hrdata, last_rdata);
            end else begin
                mon_it   = q[0];
                mon_n    = cyc - mon_it.acc + 1;
                exp_psel = mon_it.err ? 4'b0 : (4'b0001 << mon_it.addr[9:8]);
                if (Penable) pen_cnt++;
                if (Psel != 4'b0 && !Penable) setup_cnt++;
                chk(Hresp == (mon_it.err ? 2'b01 : 2'b00), "hresp", 32'(Hresp),
                    mon_it.err ? 32'd1 : 32'd0);
                chk(Psel == 4'b0 || Psel == exp_psel, "psel", 32'(Psel), 32'(exp_psel));
                chk(!Penable || Psel != 4'b0, "penable_without_psel", 32'(Penable), 32'd0);
                if (Hready_out) begin
                    chk(mon_n == mon_it.lat, "latency", 32'(mon_n), 32'(mon_it.lat));
                    chk(Hrdata == mon_it.hrdata, "hrdata", Hrdata, mon_it.hrdata);
                    chk(pen_cnt == (mon_it.err ? 0 : mon_it.waits + 1), "penable_cycles",
                        32'(pen_cnt), mon_it.err ? 32'd0 : 32'(mon_it.waits + 1));
                    chk(setup_cnt == (mon_it.err ? 0 : 1), "setup_cycles", 32'(setup_cnt),
                        mon_it.err ? 32'd0 : 32'd1);
                    chk(Paddr == mon_it.addr && Pwrite == mon_it.wr, "paddr_pwrite", Paddr,
                        mon_it.addr);
                    if (mon_it.wr && !mon_it.err)
                        chk(Pwdata == mon_it.wdata, "pwdata", Pwdata, mon_it.wdata);
                    void'(q.pop_front());
                    pen_cnt   = 0;
                    setup_cnt = 0;
                end else begin
                    chk(Hrdata == mon_it.prev_rdata, "hrdata_hold", Hrdata, mon_it.prev_rdata);
                end
            end
        end
    end

    task automatic check_reset_state();
        chk(Hready_out == 1'b1, "rst_hready", 32'(Hready_out), 32'd1);
        chk(Hresp == 2'b00, "rst_hresp", 32'(Hresp), 32'd0);
        chk(Hrdata == 32'd0, "rst_hrdata", Hrdata, 32'd0);
        chk(Paddr == 32'd0 && Pwrite == 1'b0, "rst_paddr_pwrite", Paddr, 32'd0);
        chk(Pwdata == 32'd0, "rst_pwdata", Pwdata, 32'd0);
        chk(Psel == 4'b0 && !Penable, "rst_psel_penable", {27'b0, Psel, Penable}, 32'd0);
    endtask

    // Called at a negedge; non-accepting bus activity for n cycles.
    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: begin Hsel = 1'b0; Htrans = 2'($urandom); Hready_in = 1'b1; end
                1: begin Hsel = 1'b1; Htrans = {1'b0, 1'($urandom)}; Hready_in = 1'b1; end
                default: begin Hsel = 1'b1; Htrans = 2'b10; Hready_in = 1'b0; end
            endcase
            Haddr  = $urandom;
            Hwrite = 1'($urandom);
            Hwdata = $urandom;
            @(negedge Hclk);
        end
    endtask

    task automatic wait_ready(input bit randomize_wdata);
        int k;
        k = 0;
        while (!Hready_out && k < 50) begin
            @(negedge Hclk);
            k++;
            if (randomize_wdata && k >= 2) Hwdata = $urandom;
        end
        if (!Hready_out) begin
            chk(1'b0, "hready_timeout", 32'(Hready_out), 32'd1);
            finish_sim();
        end
    endtask

    // Called at a negedge; issues one transfer and returns once Hready_out is back high.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits);
        item_t it;
        wait_ready(1'b0);
        Hsel      = 1'b1;
        Htrans    = $urandom_range(0, 1) ? 2'b11 : 2'b10;
        Haddr     = addr;
        Hwrite    = wr;
        Hready_in = 1'b1;
        Hwdata    = $urandom;
        @(posedge Hclk);
        #1;
        it.addr       = addr;
        it.wr         = wr;
        it.wdata      = wdata;
        it.waits      = waits;
        it.prev_rdata = last_rdata;
        it.err        = addr[11:8] > 4'd3;
        if (!it.err && !wr) last_rdata = rdata;
        it.hrdata     = last_rdata;
        it.lat        = it.err ? 2 : (wr ? 4 : 3) + waits;
        it.acc        = cyc;
        last_addr     = addr;
        q.push_back(it);
        cur_waits = waits;
        cur_rdata = rdata;
        Hsel      = 1'($urandom);
        Htrans    = {1'b0, 1'($urandom)};
        Haddr     = $urandom;
        Hwrite    = 1'($urandom);
        Hwdata    = wdata;
        wait_ready(1'b1);
    endtask

    task automatic reset_mid();
        int k;
        noise(1);
        mon_en = 1'b0;
        Hsel = 1'b1; Htrans = 2'b10; Haddr = 32'h0000_0304; Hwrite = 1'b0; Hready_in = 1'b1;
        @(posedge Hclk);
        #1;
        cur_waits = 100;
        cur_rdata = 32'h5555_AAAA;
        Htrans    = 2'b00;
        k = 0;
        while (!Penable && k < 10) begin
            @(negedge Hclk);
            k++;
        end
        @(negedge Hclk);
        chk(Penable && !Hready_out, "stalled_access", {30'b0, Penable, Hready_out}, 32'd2);
        Hrst = 1'b1;
        @(posedge Hclk);
        #1;
        check_reset_state();
        @(negedge Hclk);
        Hsel = 1'b1; Htrans = 2'b10; Haddr = 32'h0000_0100; Hwrite = 1'b1;
        @(posedge Hclk);
        #1;
        chk(Hready_out && Psel == 4'b0 && Paddr == 32'd0 && !Pwrite, "req_during_reset", Paddr,
            32'd0);
        @(negedge Hclk);
        Hrst = 1'b0; Hsel = 1'b0; Htrans = 2'b00;
        q.delete();
        last_rdata = '0;
        last_addr  = '0;
        cur_waits  = 0;
        mon_en     = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        Hrst = 1'b1; Hsel = 1'b0; Haddr = '0; Htrans = 2'b00; Hwrite = 1'b0;
        Hwdata = '0; Hready_in = 1'b1;
        repeat (2) @(posedge Hclk);
        #1;
        check_reset_state();
        @(negedge Hclk);
        Hrst   = 1'b0;
        mon_en = 1'b1;
        noise(2);

        xfer(32'h0000_0204, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
        noise(1);
        xfer(32'h0000_0100, 1'b1, 32'h1234_5678, $urandom, 0);
        xfer(32'h0000_0004, 1'b0, 32'h0, 32'hCAFE_F00D, 3);
        xfer(32'h0000_0500, 1'b0, 32'h0, $urandom, 0);
        xfer(32'h0000_0308, 1'b0, 32'h0, 32'h0BAD_F00D, 0);
        noise(5);
        reset_mid();
        noise(2);

        for (int t = 0; t < 150; t++) begin
            a = $urandom;
            a[11:8] = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 3))
                                                 : 4'($urandom_range(4, 15));
            xfer(a, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
            noise($urandom_range(0, 2));
        end
        noise(3);
        finish_sim();
    end

endmodule
